// File: rtl/uart_transmitter.sv
// UART transmit path: frames a parallel word as start, data (LSB first), optional parity
// and stop bits, one serial bit per OVERSAMPLE cycles of the 16x baud clock.
//
// state    | meaning
// S_IDLE   | line high, waiting for Tx_start
// S_START  | start bit (line low)
// S_DATA   | data bits, index 0 first
// S_PARITY | parity bit (only reachable when PARITY_EN=1)
// S_STOP   | stop bit(s), Tx_done in the very last cycle
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Bclkx16_,
  input  logic                 reset,
  input  logic                 Tx_start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 Tx,
  output logic                 Tx_busy,
  output logic                 Tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_end  = (tick_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        if (Tx_start) begin
          state_d  = S_START;
          tick_d   = '0;
          bit_d    = '0;
          shift_d  = data;
          parity_d = (^data) ^ ODD;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      if (bit_end) tick_d = '0;
      else         tick_d = tick_q + 1'b1;
    end

    // Outputs are decoded from the next state so that they come straight out of flops.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (tick_d == TICK_LAST) && (bit_d == STOP_LAST);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge Bclkx16_) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Tx      = tx_q;
  assign Tx_busy = busy_q;
  assign Tx_done = done_q;

endmodule
